// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared definitions for the load/store unit.
//   DATA_W         : datapath width (fixed at 32)
//   SZ_*           : req_size encodings (2'b11 is illegal)
//   lsu_state_t    : FSM states of the load/store unit
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align: combinational lane handling for the load/store unit.
//   i_rd_word : word read from memory
//   i_wdata   : right-justified store data
//   i_lane    : byte address bits [1:0] of the access
//   i_size    : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_signed  : sign-extend sub-word loads
//   o_load    : extracted, extended load result
//   o_merged  : i_rd_word with the addressed lane replaced by i_wdata
// Lanes are little-endian: byte 0 occupies bits 7:0.
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] i_rd_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);

    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_lane_mask;

    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_rd_word >> w_shamt;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        o_load      = w_shifted;
        w_lane_mask = '1;
        case (i_size)
            SZ_BYTE: begin
                o_load      = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
                w_lane_mask = 32'h0000_00FF << w_shamt;
            end
            SZ_HALF: begin
                o_load      = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
                w_lane_mask = 32'h0000_FFFF << w_shamt;
            end
            default: ;
        endcase
        // Only the addressed lane takes store data; other bytes keep memory.
        o_merged = (i_rd_word & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit: byte/half/word load-store stage in front of a 256x32
// word-addressed DataMemory without byte enables. Sub-word stores are done
// as read-modify-write (READ then WRITE).
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata : request fields, latched on accept
//   resp_valid/resp_ready      : response handshake
//   resp_rdata, resp_err       : load result (0 for stores/errors), error flag
//   mem_mw/mem_mr/mem_a/mem_wd : registered DataMemory controls
//   mem_rd                     : DataMemory read data (valid while mem_mr)
// Parameter ADDR_W: word-index width (depth 2**ADDR_W). Data width is fixed
// at lsu_pkg::DATA_W = 32.
// Optional macro LSU_RANGE_CHECK_EN: flags req_addr[31:ADDR_W+2] != 0 as an
// error; otherwise upper address bits are ignored and the index wraps.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_mw,
    output logic              mem_mr,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_req_err;
    logic              w_range_err;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

`ifdef LSU_RANGE_CHECK_EN
    assign w_range_err = |req_addr[31:ADDR_W+2];
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |req_addr[31:ADDR_W+2];
    assign w_range_err      = 1'b0;
`endif

    assign w_req_err = (req_size == SZ_ILLEGAL)
                    || (req_size == SZ_HALF && req_addr[0])
                    || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                    || w_range_err;

    lsu_align u_align (
        .i_rd_word (mem_rd),
        .i_wdata   (r_wdata),
        .i_lane    (r_lane),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err)                         w_next_state = RESP;
                    else if (req_we && req_size == SZ_WORD) w_next_state = WRITE;
                    else                                   w_next_state = READ;
                end
            end
            READ:    w_next_state = r_we ? WRITE : RESP;
            WRITE:   w_next_state = RESP;
            RESP:    if (resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly
    // with the READ / WRITE states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SZ_BYTE;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_mw     <= 1'b0;
            mem_mr     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            mem_mr <= (w_next_state == READ);
            mem_mw <= (w_next_state == WRITE);

            if (w_accept) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_lane   <= req_addr[1:0];
                r_wdata  <= req_wdata;
                if (w_req_err) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    mem_a  <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                    mem_wd <= req_wdata;   // used as-is by word stores
                end
            end

            if (r_state == READ) begin
                if (r_we) begin
                    mem_wd <= w_merged;
                end else begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= w_load;
                end
            end

            if (r_state == WRITE) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end

            if (r_state == RESP && resp_ready) resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit: self-checking bench for load_store_unit. A byte-level
// reference memory predicts load data, errors, latency and strobe activity.
// Define LSU_RANGE_CHECK_EN for both RTL and bench to exercise that option.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_mw, mem_mr;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem   [256];
    logic [7:0]  mbytes [1024];

    always #5 clk = ~clk;

    // DataMemory: synchronous write, combinational read, high-Z when idle.
    always @(posedge clk) if (mem_mw) dmem[mem_a[7:0]] <= mem_wd;
    assign mem_rd = mem_mr ? dmem[mem_a[7:0]] : 32'hzzzz_zzzz;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_mw(mem_mw), .mem_mr(mem_mr), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    // ---------------- reference model (byte-addressed) ----------------
    function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= 32'h400) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        return {mbytes[4*idx+3], mbytes[4*idx+2], mbytes[4*idx+1], mbytes[4*idx]};
    endfunction

    task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] e_rdata, output logic e_err,
                                output int e_lat, output int e_mr, output int e_mw);
        int n, base;
        logic [31:0] v, ones;
        e_err = exp_err(size, addr);
        e_rdata = '0; e_mr = 0; e_mw = 0; e_lat = 1;
        if (e_err) return;
        n    = 1 << size;
        base = int'(addr[9:0]);
        if (we) begin
            for (int k = 0; k < n; k++) mbytes[base+k] = wdata[8*k +: 8];
            e_mw  = 1;
            e_mr  = (n < 4) ? 1 : 0;
            e_lat = (n < 4) ? 3 : 2;
        end else begin
            v = '0;
            for (int k = 0; k < n; k++) v = v | (32'(mbytes[base+k]) << (8*k));
            if (sgn && n < 4 && v[8*n-1]) begin
                ones = (32'd1 << (8*n)) - 32'd1;
                v = v | ~ones;
            end
            e_rdata = v; e_mr = 1; e_lat = 2;
        end
    endtask

    // ---------------- stimulus driver (observations only) ----------------
    // Entered #1 after a rising edge; returns #1 after the response is taken.
    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int n_mr, output int n_mw, output int both,
                       output logic [31:0] a_seen, output logic [31:0] wd_seen);
        n_mr = 0; n_mw = 0; both = 0; lat = -1; a_seen = '0; wd_seen = '0;
        rdata = 'x; err = 1'bx;
        for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_mr) begin n_mr++; a_seen = mem_a; end
            if (mem_mw) begin n_mw++; wd_seen = mem_wd; end
            if (mem_mr && mem_mw) both++;
            if (resp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            rdata = resp_rdata; err = resp_err;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: ready=%b rv=%b err=%b expected 1 0 0",
                            req_ready, resp_valid, resp_err);
        end
        total++;
        if (resp_rdata !== 32'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            bad++; $display("FAIL reset_data: rdata=%h a=%h wd=%h expected zeros",
                            resp_rdata, mem_a, mem_wd);
        end
        total++;
        if (mem_mr !== 1'b0 || mem_mw !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: mr=%b mw=%b expected 0 0", mem_mr, mem_mw);
        end
    endtask

    task automatic test_load_word();
        logic [31:0] rd, a, wd, er; logic err, ee; int lat, nmr, nmw, both, el, emr, emw;
        model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, er, ee, el, emr, emw);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (rd !== 32'h0000_000C || err !== 1'b0) begin
            bad++; $display("FAIL load_word: rdata=%h err=%b expected 0000000c 0", rd, err);
        end
        total++;
        if (lat !== 2 || nmr !== 1 || nmw !== 0 || a !== 32'd4) begin
            bad++; $display("FAIL load_word_timing: lat=%0d mr=%0d mw=%0d a=%0d expected 2 1 0 4",
                            lat, nmr, nmw, a);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, a, wd, er; logic err, ee; int lat, nmr, nmw, both, el, emr, emw;
        model_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, er, ee, el, emr, emw);
        txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (lat !== 2 || nmr !== 0 || nmw !== 1 || wd !== 32'hDEADBEEF || rd !== 32'h0) begin
            bad++; $display("FAIL store_word: lat=%0d mr=%0d mw=%0d wd=%h rdata=%h expected 2 0 1 deadbeef 0",
                            lat, nmr, nmw, wd, rd);
        end
        model_access(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, er, ee, el, emr, emw);
        txn(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (rd !== 32'hFFFF_FFDE || rd !== er || lat !== 2) begin
            bad++; $display("FAIL load_byte_signed: rdata=%h lat=%0d expected ffffffde 2", rd, lat);
        end
        model_access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, er, ee, el, emr, emw);
        txn(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (rd !== 32'h0000_BEEF || rd !== er) begin
            bad++; $display("FAIL load_half_unsigned: rdata=%h expected 0000beef", rd);
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd, a, wd, er; logic err, ee; int lat, nmr, nmw, both, el, emr, emw;
        model_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055, er, ee, el, emr, emw);
        txn(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (lat !== 3 || nmr !== 1 || nmw !== 1 || both !== 0 || wd !== 32'hDEAD55EF) begin
            bad++; $display("FAIL store_byte_rmw: lat=%0d mr=%0d mw=%0d both=%0d wd=%h expected 3 1 1 0 dead55ef",
                            lat, nmr, nmw, both, wd);
        end
        model_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, er, ee, el, emr, emw);
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (rd !== 32'hDEAD55EF || rd !== er) begin
            bad++; $display("FAIL load_after_rmw: rdata=%h expected dead55ef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, a, wd; logic err; int lat, nmr, nmw, both;
        txn(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || nmr !== 0 || nmw !== 0) begin
            bad++; $display("FAIL err_misaligned_half: err=%b rdata=%h lat=%0d mr=%0d mw=%0d expected 1 0 1 0 0",
                            err, rd, lat, nmr, nmw);
        end
        txn(1'b1, 2'b11, 1'b0, 32'h24, 32'h1234_5678, rd, err, lat, nmr, nmw, both, a, wd);
        total++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || nmr !== 0 || nmw !== 0) begin
            bad++; $display("FAIL err_illegal_size: err=%b rdata=%h lat=%0d mr=%0d mw=%0d expected 1 0 1 0 0",
                            err, rd, lat, nmr, nmw);
        end
    endtask

    task automatic test_hold();
        logic [31:0] er; logic ee; int el, emr, emw;
        model_access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, er, ee, el, emr, emw);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_signed = 1'b1; req_addr = 32'h22;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== er || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: rv=%b rdata=%h err=%b ready=%b expected 1 %h 0 0",
                                c, resp_valid, resp_rdata, resp_err, req_ready, er);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release: rv=%b ready=%b expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_write();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (mem_mw !== 1'b1) begin
            bad++; $display("FAIL rst_write_entry: mw=%b expected 1", mem_mw);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_mw !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_async: mw=%b ready=%b rv=%b expected 0 1 0",
                            mem_mw, req_ready, resp_valid);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dmem[12] !== model_word(12)) begin
            bad++; $display("FAIL rst_word_kept: mem=%h expected %h", dmem[12], model_word(12));
        end
    endtask

    task automatic test_range();
        logic [31:0] rd, a, wd, er; logic err, ee; int lat, nmr, nmw, both, el, emr, emw;
        model_access(1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_A5A5, er, ee, el, emr, emw);
        txn(1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_A5A5, rd, err, lat, nmr, nmw, both, a, wd);
`ifdef LSU_RANGE_CHECK_EN
        total++;
        if (err !== 1'b1 || nmw !== 0 || dmem[0] !== 32'h0000_000C) begin
            bad++; $display("FAIL range_err: err=%b mw=%0d mem0=%h expected 1 0 0000000c", err, nmw, dmem[0]);
        end
`else
        total++;
        if (err !== 1'b0 || nmw !== 1 || dmem[0] !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL range_wrap: err=%b mw=%0d mem0=%h expected 0 1 a5a5a5a5", err, nmw, dmem[0]);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, er, addr, wdata; logic err, ee, we, sgn;
        logic [1:0] size; int lat, nmr, nmw, both, el, emr, emw, r, diffs;
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            addr = $urandom; wdata = $urandom;
            if ($urandom_range(0, 7) != 0) addr[31:10] = '0;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b10) addr[1:0] = 2'b00;
            end
            model_access(we, size, sgn, addr, wdata, er, ee, el, emr, emw);
            txn(we, size, sgn, addr, wdata, rd, err, lat, nmr, nmw, both, a, wd);
            total++;
            if (rd !== er || err !== ee) begin
                bad++; $display("FAIL rand%0d_data: we=%b sz=%0d addr=%h rdata=%h err=%b expected %h %b",
                                t, we, size, addr, rd, err, er, ee);
            end
            total++;
            if (lat !== el || nmr !== emr || nmw !== emw || both !== 0) begin
                bad++; $display("FAIL rand%0d_timing: lat=%0d mr=%0d mw=%0d both=%0d expected %0d %0d %0d 0",
                                t, lat, nmr, nmw, both, el, emr, emw);
            end
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== model_word(i)) diffs++;
        total++;
        if (diffs != 0) begin
            bad++; $display("FAIL memory_image: %0d words differ, expected 0", diffs);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mbytes[i] = (i % 4 == 0) ? 8'd12 : 8'd0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'd12;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_word();
        test_store_load();
        test_subword_store();
        test_errors();
        test_hold();
        test_reset_in_write();
        test_reset();
        test_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
